// File: rtl/dll_initfc_ctrl.sv
// dll_initfc_ctrl: VC0 flow-control initialisation engine.
// Sends InitFC1/InitFC2 sets and captures partner credits.
module dll_initfc_ctrl #(
  parameter logic [7:0]  P_HDR         = 8'd32,
  parameter logic [11:0] P_DATA        = 12'd256,
  parameter logic [7:0]  NP_HDR        = 8'd32,
  parameter logic [11:0] NP_DATA       = 12'd64,
  parameter logic [7:0]  CPL_HDR       = 8'd0,
  parameter logic [11:0] CPL_DATA      = 12'd0,
  parameter logic [15:0] RESEND_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dl_state_i,
  output logic        tx_dllp_valid_o,
  input  logic        tx_dllp_ready_i,
  output logic [7:0]  tx_dllp_type_o,
  output logic [7:0]  tx_hdr_fc_o,
  output logic [11:0] tx_data_fc_o,
  input  logic        rx_dllp_valid_i,
  input  logic [7:0]  rx_dllp_type_i,
  input  logic [7:0]  rx_hdr_fc_i,
  input  logic [11:0] rx_data_fc_i,
  output logic        initfc_sent_o,
  output logic        initfc_received_o,
  output logic        initfc2_sent_o,
  output logic        initfc2_received_o,
  output logic [7:0]  rmt_p_hdr_o,
  output logic [11:0] rmt_p_data_o,
  output logic [7:0]  rmt_np_hdr_o,
  output logic [11:0] rmt_np_data_o,
  output logic [7:0]  rmt_cpl_hdr_o,
  output logic [11:0] rmt_cpl_data_o,
  output logic        rmt_credit_valid_o
);

  localparam logic [1:0] DL_INACTIVE = 2'b00;
  localparam logic [1:0] DL_INIT1    = 2'b01;
  localparam logic [1:0] DL_INIT2    = 2'b10;
  localparam logic [1:0] DL_ACTIVE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_P,
    S_SEND_NP,
    S_SEND_CPL,
    S_WAIT
  } tx_state_t;

  tx_state_t   state_q;
  tx_state_t   state_d;
  logic        phase2_q;
  logic        phase2_d;
  logic [15:0] timer_q;
  logic [15:0] timer_d;

  logic        dl_off;
  logic        in_init;
  logic        sending;
  logic        hs;
  logic        switch_fc2;
  logic        cpl_hs;
  logic        set1;
  logic        set2;

  logic        sent1_q;
  logic        sent2_q;
  logic        rcvd2_q;
  logic [2:0]  rx_seen_q;
  logic [2:0]  rx_hit;
  logic [2:0]  rx_cap;
  logic        rx_fc2_upd;

  assign dl_off  = (dl_state_i == DL_INACTIVE);
  assign in_init = (dl_state_i == DL_INIT1) ||
                   (dl_state_i == DL_INIT2);
  assign sending = (state_q == S_SEND_P)  ||
                   (state_q == S_SEND_NP) ||
                   (state_q == S_SEND_CPL);
  assign hs      = tx_dllp_valid_o && tx_dllp_ready_i;

  // an InitFC1 set in flight is abandoned once INIT2 is seen
  assign switch_fc2 = !phase2_q && (dl_state_i == DL_INIT2);

  assign cpl_hs = hs && (state_q == S_SEND_CPL);
  assign set1   = cpl_hs && !phase2_q &&
                  (dl_state_i == DL_INIT1);
  assign set2   = cpl_hs && phase2_q &&
                  (dl_state_i == DL_INIT2);

  // TX state, phase and resend timer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase2_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase2_q <= phase2_d;
      timer_q  <= timer_d;
    end
  end

  // TX next-state: walk P/NP/Cpl, then idle gap
  always_comb begin
    state_d  = state_q;
    phase2_d = phase2_q;
    timer_d  = timer_q;
    if (dl_off) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_init) begin
            state_d  = S_SEND_P;
            phase2_d = (dl_state_i == DL_INIT2);
          end
        end
        S_SEND_P, S_SEND_NP, S_SEND_CPL: begin
          if (hs) begin
            if (dl_state_i == DL_ACTIVE) begin
              state_d = S_IDLE;
            end else if (switch_fc2) begin
              state_d  = S_SEND_P;
              phase2_d = 1'b1;
            end else if (state_q == S_SEND_P) begin
              state_d = S_SEND_NP;
            end else if (state_q == S_SEND_NP) begin
              state_d = S_SEND_CPL;
            end else begin
              state_d = S_WAIT;
              timer_d = RESEND_CYCLES - 16'd1;
            end
          end
        end
        S_WAIT: begin
          if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
          end else if (in_init) begin
            state_d  = S_SEND_P;
            phase2_d = (dl_state_i == DL_INIT2);
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // TX outputs: fields follow the state, valid masked by INACTIVE
  always_comb begin
    tx_dllp_valid_o = 1'b0;
    tx_dllp_type_o  = '0;
    tx_hdr_fc_o     = '0;
    tx_data_fc_o    = '0;
    unique case (state_q)
      S_SEND_P: begin
        tx_dllp_type_o = {phase2_q, 3'b100, 4'h0};
        tx_hdr_fc_o    = P_HDR;
        tx_data_fc_o   = P_DATA;
      end
      S_SEND_NP: begin
        tx_dllp_type_o = {phase2_q, 3'b101, 4'h0};
        tx_hdr_fc_o    = NP_HDR;
        tx_data_fc_o   = NP_DATA;
      end
      S_SEND_CPL: begin
        tx_dllp_type_o = {phase2_q, 3'b110, 4'h0};
        tx_hdr_fc_o    = CPL_HDR;
        tx_data_fc_o   = CPL_DATA;
      end
      default: ;
    endcase
    tx_dllp_valid_o = sending && !dl_off;
  end

  // RX decode: per-type InitFC hit and InitFC2/UpdateFC hit
  always_comb begin
    rx_hit     = 3'b000;
    rx_fc2_upd = 1'b0;
    unique case (1'b1)
      rx_dllp_type_i == 8'h40: rx_hit = 3'b001;
      rx_dllp_type_i == 8'h50: rx_hit = 3'b010;
      rx_dllp_type_i == 8'h60: rx_hit = 3'b100;
      rx_dllp_type_i == 8'hC0: begin
        rx_hit     = 3'b001;
        rx_fc2_upd = 1'b1;
      end
      rx_dllp_type_i == 8'hD0: begin
        rx_hit     = 3'b010;
        rx_fc2_upd = 1'b1;
      end
      rx_dllp_type_i == 8'hE0: begin
        rx_hit     = 3'b100;
        rx_fc2_upd = 1'b1;
      end
      rx_dllp_type_i == 8'h80,
      rx_dllp_type_i == 8'h90,
      rx_dllp_type_i == 8'hA0: rx_fc2_upd = 1'b1;
      default: ;
    endcase
  end

  assign rx_cap = rx_hit &
    {3{rx_dllp_valid_i && (dl_state_i == DL_INIT1)}};

  // sticky sent/received status, cleared by INACTIVE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent1_q <= 1'b0;
      sent2_q <= 1'b0;
      rcvd2_q <= 1'b0;
    end else if (dl_off) begin
      sent1_q <= 1'b0;
      sent2_q <= 1'b0;
      rcvd2_q <= 1'b0;
    end else begin
      if (set1) sent1_q <= 1'b1;
      if (set2) sent2_q <= 1'b1;
      if (rx_dllp_valid_i && rx_fc2_upd &&
          (dl_state_i == DL_INIT2))
        rcvd2_q <= 1'b1;
    end
  end

  // first InitFC per type latches partner credits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_seen_q      <= '0;
      rmt_p_hdr_o    <= '0;
      rmt_p_data_o   <= '0;
      rmt_np_hdr_o   <= '0;
      rmt_np_data_o  <= '0;
      rmt_cpl_hdr_o  <= '0;
      rmt_cpl_data_o <= '0;
    end else if (dl_off) begin
      rx_seen_q      <= '0;
      rmt_p_hdr_o    <= '0;
      rmt_p_data_o   <= '0;
      rmt_np_hdr_o   <= '0;
      rmt_np_data_o  <= '0;
      rmt_cpl_hdr_o  <= '0;
      rmt_cpl_data_o <= '0;
    end else begin
      if (rx_cap[0] && !rx_seen_q[0]) begin
        rmt_p_hdr_o  <= rx_hdr_fc_i;
        rmt_p_data_o <= rx_data_fc_i;
      end
      if (rx_cap[1] && !rx_seen_q[1]) begin
        rmt_np_hdr_o  <= rx_hdr_fc_i;
        rmt_np_data_o <= rx_data_fc_i;
      end
      if (rx_cap[2] && !rx_seen_q[2]) begin
        rmt_cpl_hdr_o  <= rx_hdr_fc_i;
        rmt_cpl_data_o <= rx_data_fc_i;
      end
      rx_seen_q <= rx_seen_q | rx_cap;
    end
  end

  assign initfc_sent_o      = sent1_q;
  assign initfc2_sent_o     = sent2_q;
  assign initfc2_received_o = rcvd2_q;
  assign initfc_received_o  = &rx_seen_q;
  assign rmt_credit_valid_o = &rx_seen_q;

endmodule

// File: tb/tb_dll_initfc_ctrl.sv
// tb_dll_initfc_ctrl: directed + random bench for dll_initfc_ctrl
// against a set-position reference model.
module tb_dll_initfc_ctrl;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dl_state_i = 2'd0;
  logic        tx_dllp_ready_i = 1'b0;
  logic        rx_dllp_valid_i = 1'b0;
  logic [7:0]  rx_dllp_type_i = 8'd0;
  logic [7:0]  rx_hdr_fc_i = 8'd0;
  logic [11:0] rx_data_fc_i = 12'd0;

  logic        tx_dllp_valid_o;
  logic [7:0]  tx_dllp_type_o;
  logic [7:0]  tx_hdr_fc_o;
  logic [11:0] tx_data_fc_o;
  logic        initfc_sent_o;
  logic        initfc_received_o;
  logic        initfc2_sent_o;
  logic        initfc2_received_o;
  logic [7:0]  rmt_p_hdr_o;
  logic [11:0] rmt_p_data_o;
  logic [7:0]  rmt_np_hdr_o;
  logic [11:0] rmt_np_data_o;
  logic [7:0]  rmt_cpl_hdr_o;
  logic [11:0] rmt_cpl_data_o;
  logic        rmt_credit_valid_o;

  dll_initfc_ctrl #(
    .RESEND_CYCLES(16'(R))
  ) dut (
    .clk(clk),
    .rst(rst),
    .dl_state_i(dl_state_i),
    .tx_dllp_valid_o(tx_dllp_valid_o),
    .tx_dllp_ready_i(tx_dllp_ready_i),
    .tx_dllp_type_o(tx_dllp_type_o),
    .tx_hdr_fc_o(tx_hdr_fc_o),
    .tx_data_fc_o(tx_data_fc_o),
    .rx_dllp_valid_i(rx_dllp_valid_i),
    .rx_dllp_type_i(rx_dllp_type_i),
    .rx_hdr_fc_i(rx_hdr_fc_i),
    .rx_data_fc_i(rx_data_fc_i),
    .initfc_sent_o(initfc_sent_o),
    .initfc_received_o(initfc_received_o),
    .initfc2_sent_o(initfc2_sent_o),
    .initfc2_received_o(initfc2_received_o),
    .rmt_p_hdr_o(rmt_p_hdr_o),
    .rmt_p_data_o(rmt_p_data_o),
    .rmt_np_hdr_o(rmt_np_hdr_o),
    .rmt_np_data_o(rmt_np_data_o),
    .rmt_cpl_hdr_o(rmt_cpl_hdr_o),
    .rmt_cpl_data_o(rmt_cpl_data_o),
    .rmt_credit_valid_o(rmt_credit_valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // reference model: position in set (-1 idle, 0..2, 3 gap)
  int         m_pos;
  int         m_gap;
  bit         m_fc2;
  bit         m_s1, m_s2, m_r2;
  bit         m_seen [3];
  logic [7:0] m_hdr  [3];
  logic [11:0] m_dat [3];

  localparam logic [7:0]  LHDR [3] = '{8'd32, 8'd32, 8'd0};
  localparam logic [11:0] LDAT [3] = '{12'd256, 12'd64, 12'd0};

  logic [7:0] codes [12] = '{8'h40, 8'h50, 8'h60, 8'hC0,
                             8'hD0, 8'hE0, 8'h80, 8'h90,
                             8'hA0, 8'h00, 8'h41, 8'hF0};

  task automatic model_clear();
    m_pos = -1; m_gap = 0; m_fc2 = 0;
    m_s1 = 0; m_s2 = 0; m_r2 = 0;
    for (int i = 0; i < 3; i++) begin
      m_seen[i] = 0; m_hdr[i] = '0; m_dat[i] = '0;
    end
  endtask

  task automatic check_all();
    bit v;
    bit all3;
    v = (m_pos >= 0) && (m_pos < 3) && (dl_state_i != 2'd0);
    all3 = m_seen[0] && m_seen[1] && m_seen[2];
    chk("valid", tx_dllp_valid_o, v);
    if (v) begin
      chk("type", tx_dllp_type_o,
          8'((m_fc2 ? 32'hC0 : 32'h40) + 16 * m_pos));
      chk("hdr", tx_hdr_fc_o, LHDR[m_pos]);
      chk("data", tx_data_fc_o, LDAT[m_pos]);
    end
    chk("sent1", initfc_sent_o, m_s1);
    chk("sent2", initfc2_sent_o, m_s2);
    chk("rcvd1", initfc_received_o, all3);
    chk("rcvd2", initfc2_received_o, m_r2);
    chk("crval", rmt_credit_valid_o, all3);
    chk("p_hdr", rmt_p_hdr_o, m_hdr[0]);
    chk("p_dat", rmt_p_data_o, m_dat[0]);
    chk("np_hdr", rmt_np_hdr_o, m_hdr[1]);
    chk("np_dat", rmt_np_data_o, m_dat[1]);
    chk("cpl_hdr", rmt_cpl_hdr_o, m_hdr[2]);
    chk("cpl_dat", rmt_cpl_data_o, m_dat[2]);
  endtask

  task automatic model_step();
    int k;
    bit hs;
    bit init;
    if (dl_state_i == 2'd0) begin
      model_clear();
      return;
    end
    init = (dl_state_i == 2'd1) || (dl_state_i == 2'd2);
    hs = (m_pos >= 0) && (m_pos < 3) && tx_dllp_ready_i;
    if (m_pos < 0) begin
      if (init) begin
        m_pos = 0; m_fc2 = (dl_state_i == 2'd2);
      end
    end else if (m_pos == 3) begin
      m_gap--;
      if (m_gap == 0) begin
        if (init) begin
          m_pos = 0; m_fc2 = (dl_state_i == 2'd2);
        end else begin
          m_pos = -1;
        end
      end
    end else if (hs) begin
      if (dl_state_i == 2'd3) begin
        m_pos = -1;
      end else if (!m_fc2 && dl_state_i == 2'd2) begin
        m_pos = 0; m_fc2 = 1;
      end else if (m_pos < 2) begin
        m_pos++;
      end else begin
        if (!m_fc2 && dl_state_i == 2'd1) m_s1 = 1;
        if (m_fc2 && dl_state_i == 2'd2) m_s2 = 1;
        m_pos = 3; m_gap = R;
      end
    end
    if (rx_dllp_valid_i) begin
      case (rx_dllp_type_i)
        8'h40, 8'hC0: k = 0;
        8'h50, 8'hD0: k = 1;
        8'h60, 8'hE0: k = 2;
        default:      k = -1;
      endcase
      if (dl_state_i == 2'd1 && k >= 0) begin
        if (!m_seen[k]) begin
          m_hdr[k] = rx_hdr_fc_i;
          m_dat[k] = rx_data_fc_i;
        end
        m_seen[k] = 1;
      end
      if (dl_state_i == 2'd2 &&
          (rx_dllp_type_i inside {8'hC0, 8'hD0, 8'hE0,
                                  8'h80, 8'h90, 8'hA0}))
        m_r2 = 1;
    end
  endtask

  task automatic cycle(input logic [1:0]  dl,
                       input logic        rdy,
                       input logic        rv = 1'b0,
                       input logic [7:0]  rt = 8'h00,
                       input logic [7:0]  rh = 8'h00,
                       input logic [11:0] rd = 12'h000);
    @(negedge clk);
    dl_state_i      = dl;
    tx_dllp_ready_i = rdy;
    rx_dllp_valid_i = rv;
    rx_dllp_type_i  = rt;
    rx_hdr_fc_i     = rh;
    rx_data_fc_i    = rd;
    #1;
    check_all();
    model_step();
  endtask

  bit         found;
  logic [1:0] rdl;

  initial begin
    model_clear();
    rst = 1'b1;
    #12;
    chk("rst_valid", tx_dllp_valid_o, 0);
    chk("rst_type", tx_dllp_type_o, 0);
    chk("rst_hdr", tx_hdr_fc_o, 0);
    chk("rst_data", tx_data_fc_o, 0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    cycle(2'd0, 1'b1);
    cycle(2'd0, 1'b1);
    chk("idle_valid", tx_dllp_valid_o, 0);

    // first InitFC1 set, ready high
    cycle(2'd1, 1'b1);
    chk("t1_first", tx_dllp_valid_o, 0);
    cycle(2'd1, 1'b1);
    chk("t1_p_type", tx_dllp_type_o, 8'h40);
    chk("t1_p_hdr", tx_hdr_fc_o, 8'd32);
    chk("t1_p_dat", tx_data_fc_o, 12'd256);
    cycle(2'd1, 1'b1);
    chk("t1_np_type", tx_dllp_type_o, 8'h50);
    chk("t1_np_dat", tx_data_fc_o, 12'd64);
    cycle(2'd1, 1'b1);
    chk("t1_cpl_type", tx_dllp_type_o, 8'h60);
    cycle(2'd1, 1'b1);
    chk("t1_sent", initfc_sent_o, 1);
    chk("t1_gap", tx_dllp_valid_o, 0);
    for (int i = 0; i < 3; i++) cycle(2'd1, 1'b1);
    chk("t1_gap_end", tx_dllp_valid_o, 0);
    cycle(2'd1, 1'b1);
    chk("t1_resend", tx_dllp_type_o, 8'h40);
    chk("t1_resend_v", tx_dllp_valid_o, 1);

    // NP held while ready low
    for (int i = 0; i < 10; i++) begin
      cycle(2'd1, 1'b0);
      chk("t2_hold_type", tx_dllp_type_o, 8'h50);
      chk("t2_hold_hdr", tx_hdr_fc_o, 8'd32);
    end
    cycle(2'd1, 1'b1);
    chk("t2_np_hs", tx_dllp_type_o, 8'h50);
    cycle(2'd1, 1'b1);
    chk("t2_cpl", tx_dllp_type_o, 8'h60);

    // RX InitFC capture in INIT1
    cycle(2'd1, 1'b0, 1'b1, 8'h40, 8'd8, 12'd100);
    cycle(2'd1, 1'b0, 1'b1, 8'hD0, 8'd4, 12'd20);
    cycle(2'd1, 1'b0, 1'b1, 8'h60, 8'd0, 12'd0);
    chk("t3_not_yet", initfc_received_o, 0);
    cycle(2'd1, 1'b0, 1'b1, 8'h40, 8'd99, 12'd7);
    chk("t3_rcvd", initfc_received_o, 1);
    cycle(2'd1, 1'b0);
    chk("t3_p_hdr", rmt_p_hdr_o, 8'd8);
    chk("t3_np_dat", rmt_np_data_o, 12'd20);
    chk("t3_crval", rmt_credit_valid_o, 1);

    // INIT1 -> INIT2 while NP pending
    cycle(2'd0, 1'b0);
    cycle(2'd0, 1'b0);
    cycle(2'd1, 1'b0);
    cycle(2'd1, 1'b1);
    chk("t4_p", tx_dllp_type_o, 8'h40);
    cycle(2'd1, 1'b0);
    chk("t4_np", tx_dllp_type_o, 8'h50);
    for (int i = 0; i < 3; i++) begin
      cycle(2'd2, 1'b0);
      chk("t4_np_held", tx_dllp_type_o, 8'h50);
    end
    cycle(2'd2, 1'b1);
    chk("t4_np_hs", tx_dllp_type_o, 8'h50);
    cycle(2'd2, 1'b1);
    chk("t4_c0", tx_dllp_type_o, 8'hC0);
    cycle(2'd2, 1'b1);
    chk("t4_d0", tx_dllp_type_o, 8'hD0);
    cycle(2'd2, 1'b1);
    chk("t4_e0", tx_dllp_type_o, 8'hE0);
    cycle(2'd2, 1'b0, 1'b1, 8'h90, 8'd1, 12'd1);
    chk("t4_sent2", initfc2_sent_o, 1);
    chk("t4_sent1", initfc_sent_o, 0);
    cycle(2'd2, 1'b0);
    chk("t4_rcvd2", initfc2_received_o, 1);

    // INACTIVE aborts a pending INIT2 DLLP
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(2'd2, 1'b0);
      found = tx_dllp_valid_o;
    end
    chk("t5_pending", found, 1);
    cycle(2'd0, 1'b0);
    chk("t5_drop", tx_dllp_valid_o, 0);
    cycle(2'd0, 1'b0);
    chk("t5_valid", tx_dllp_valid_o, 0);
    chk("t5_sent2", initfc2_sent_o, 0);
    chk("t5_rcvd2", initfc2_received_o, 0);
    chk("t5_p_hdr", rmt_p_hdr_o, 0);
    chk("t5_crval", rmt_credit_valid_o, 0);
    cycle(2'd1, 1'b1);
    cycle(2'd1, 1'b1);
    chk("t5_restart", tx_dllp_type_o, 8'h40);

    // asynchronous reset mid-set
    cycle(2'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", tx_dllp_valid_o, 0);
    chk("t6_type", tx_dllp_type_o, 0);
    chk("t6_sent1", initfc_sent_o, 0);
    chk("t6_rcvd1", initfc_received_o, 0);
    model_clear();
    dl_state_i = 2'd0;
    tx_dllp_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(2'd0, 1'b1);
      chk("t6_idle", tx_dllp_valid_o, 0);
    end

    // random traffic
    rdl = 2'd1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0)
        rdl = 2'($urandom_range(0, 3));
      cycle(rdl,
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0),
            codes[$urandom_range(0, 11)],
            8'($urandom),
            12'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dll_initfc_ctrl.md
# dll_initfc_ctrl

Flow-control initialisation engine for the data link layer, VC0 only. It drives the DLL state machine's `initfc_sent_i`, `initfc_received_i`, `initfc2_sent_i` and `initfc2_received_i` inputs from its `initfc_*` outputs, and consumes that machine's 2-bit state. It transmits repeating InitFC1/InitFC2 DLLP sets (P, NP, Cpl) and tracks received InitFC/UpdateFC DLLPs. It latches the link partner's advertised credits for the TLP credit gate.

## Interface
- `P_HDR` 8'd32 / `P_DATA` 12'd256: local posted header/data credits advertised (0 = infinite)
- `NP_HDR` 8'd32 / `NP_DATA` 12'd64: local non-posted credits
- `CPL_HDR` 8'd0 / `CPL_DATA` 12'd0: local completion credits (infinite by default)
- `RESEND_CYCLES` 16'd1024: idle gap between repeated sets, in clk cycles (≥1)

Ports:
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `dl_state_i` in 2: 00 INACTIVE, 01 DL_INIT1, 10 DL_INIT2, 11 DL_ACTIVE
- `tx_dllp_valid_o` out 1 / `tx_dllp_ready_i` in 1: transmit handshake
- `tx_dllp_type_o` out 8, `tx_hdr_fc_o` out 8, `tx_data_fc_o` out 12: transmit DLLP fields
- `rx_dllp_valid_i` in 1, `rx_dllp_type_i` in 8, `rx_hdr_fc_i` in 8, `rx_data_fc_i` in 12: received, CRC-checked DLLP
- `initfc_sent_o`, `initfc_received_o`, `initfc2_sent_o`, `initfc2_received_o` out 1: status to DLL state machine
- `rmt_p_hdr_o` out 8, `rmt_p_data_o` out 12, `rmt_np_hdr_o` out 8, `rmt_np_data_o` out 12, `rmt_cpl_hdr_o` out 8, `rmt_cpl_data_o` out 12: partner credits
- `rmt_credit_valid_o` out 1: all three partner credit pairs captured

## Operation
- Type codes: InitFC1 P/NP/Cpl = 0x40/0x50/0x60; InitFC2 = 0xC0/0xD0/0xE0; UpdateFC = 0x80/0x90/0xA0. All other codes are ignored.
- TX FSM states: IDLE, SEND_P, SEND_NP, SEND_CPL, WAIT.
  - IDLE → SEND_P when `dl_state_i` is INIT1 or INIT2.
  - Each SEND state asserts valid with its type and credit fields, and advances on `valid && ready`: P → NP → CPL → WAIT.
  - On the CPL handshake, set the sticky sent flag for the current phase: `initfc_sent_o` in INIT1, `initfc2_sent_o` in INIT2. Load the timer with `RESEND_CYCLES-1`.
  - WAIT decrements the timer. At 0, go to SEND_P if the state is still INIT1 or INIT2, otherwise go to IDLE.
- Phase is sampled at each SEND_P entry: InitFC1 types in INIT1, InitFC2 types in INIT2.
- Once valid is asserted, type and fields are held stable until ready.
  - INIT1→INIT2 mid-set: finish the pending handshake, then go to SEND_P with InitFC2 types. The rest of the InitFC1 set is abandoned and `initfc_sent_o` is not set.
  - →ACTIVE: finish the pending handshake, then go to IDLE.
  - →INACTIVE: drop valid the same cycle (abort), FSM to IDLE.
- RX in INIT1:
  - InitFC1 or InitFC2 of type P/NP/Cpl sets that type's flag.
  - The first such DLLP per type captures hdr/data into `rmt_*`. Later ones are ignored.
  - `initfc_received_o` = all three flags set. `rmt_credit_valid_o` rises with it.
- RX in INIT2: any InitFC2 or UpdateFC sets `initfc2_received_o`. Credits are not recaptured.
- RX in ACTIVE: no effect. Flags and credits are held.
- INACTIVE clears all four status flags, the RX type flags, `rmt_*` and `rmt_credit_valid_o`.

## Timing
- Reset: all outputs 0, FSM IDLE, timer 0.
- `tx_dllp_valid_o` asserts the cycle after `dl_state_i` first reads INIT1 (registered).
- A DLLP with ready held high occupies 1 cycle. A full set takes 3 cycles. The next set starts `RESEND_CYCLES`+1 cycles after the CPL handshake.
- Sent flags rise the cycle after the CPL handshake. Received flags and `rmt_*` update the cycle after `rx_dllp_valid_i`.
- Simultaneous events:
  - RX capture and TX handshake in the same cycle are independent.
  - INACTIVE in the same cycle as a handshake: INACTIVE wins, and no flag is set.

## Test plan
- INIT1 with ready=1 and `RESEND_CYCLES`=4 → types 0x40, 0x50, 0x60 on consecutive cycles with hdr 32/data 256, 32/64, 0/0. `initfc_sent_o`=1 the next cycle. 0x40 reappears 5 cycles after the 0x60 handshake.
- Ready=0 for 10 cycles during SEND_NP → 0x50 and its fields held stable all 10 cycles. Advance to 0x60 only after ready goes high.
- RX 0x40 (hdr 8, data 100), then 0xD0 (hdr 4, data 20), then 0x60 (0/0), then 0x40 (hdr 99) → `initfc_received_o` rises after the third DLLP. `rmt_p_hdr_o`=8 (not 99). `rmt_np_data_o`=20.
- Switch to INIT2 while 0x50 is pending → 0x50 held until ready. Next DLLP is 0xC0. `initfc_sent_o` stays 0. `initfc2_sent_o`=1 after the 0xE0 handshake. RX 0x90 → `initfc2_received_o`=1.
- Go INACTIVE while valid is pending in INIT2 → valid 0 the next cycle. All flags and `rmt_*` are 0. Re-entering INIT1 restarts at 0x40.
- Assert `rst` mid-set → all outputs 0 asynchronously. After release, IDLE is held while `dl_state_i`=INACTIVE.
